// File: rtl/serial_adder_ctrl_if.sv
// Word-level request/response bundle for the bit-serial adder stage.
//   start      : request strobe, sampled only while the stage is idle
//   a, b, cin  : operands and carry-in, captured on the accepting edge
//   busy       : high while bits are being shifted through the cell
//   done       : one-cycle completion pulse
//   sum, cout  : last completed result; held between completions
// master = requester, slave = adder stage.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder stage: one 1-bit full-adder cell, one operand bit per
// clock, LSB first. {cout, sum} = a + b + cin, WIDTH bits plus carry.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : serial_adder_ctrl_if.slave (start/a/b/cin in, busy/done/sum/cout out)
// Timing: accept on edge k, completion on edge k+WIDTH, done high for the
// following cycle, back in IDLE after edge k+WIDTH+1.

// Combinational 1-bit full adder cell.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = x ^ y ^ c_in;
  assign c_out = (x & y) | (x & c_in) | (y & c_in);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg_a, shreg_b, acc, acc_nxt;
  logic             carry_q;
  logic [CW-1:0]    count;
  logic             cell_s, cell_c;
  logic             busy_q, done_q, cout_q;
  logic [WIDTH-1:0] sum_q;

  fa_cell u_cell (
    .x     (shreg_a[0]),
    .y     (shreg_b[0]),
    .c_in  (carry_q),
    .s     (cell_s),
    .c_out (cell_c)
  );

  // Cell sum enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  // Written as shift-then-patch so WIDTH=1 needs no special slice.
  always_comb begin
    acc_nxt            = acc >> 1;
    acc_nxt[WIDTH-1]   = cell_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg_a <= '0;
      shreg_b <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      count   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            shreg_a <= bus.a;
            shreg_b <= bus.b;
            carry_q <= bus.cin;
            count   <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          shreg_a <= shreg_a >> 1;
          shreg_b <= shreg_b >> 1;
          acc     <= acc_nxt;
          carry_q <= cell_c;
          count   <= count + CW'(1);
          // Last bit: publish the assembled word together with this bit.
          if (count == CW'(WIDTH - 1)) begin
            sum_q  <= acc_nxt;
            cout_q <= cell_c;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder stage that drives a single 1-bit full-adder cell, one operand bit per clock, LSB first.
  - Cell function: sum = x^y^c; carry = majority(x, y, c).
- Feeds the cell's x/y/c_in from internal shift registers and a carry register, and consumes its sum/c_out.
- Assembles a WIDTH-bit result with carry-out, using a start/busy/done handshake.
- Sits between a word-level requester and the 1-bit adder cell; trades latency for area.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting edge only
- b  input  WIDTH  operand B; captured on the accepting edge only
- cin  input  1  carry-in; captured on the accepting edge only
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse
- sum  output  WIDTH  result; holds the last completed value
- cout  output  1  carry-out; holds the last completed value

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry register and bit counter are cleared.
- States: IDLE, RUN, DONE. Encoding is free. All outputs are registered.
- IDLE:
  - start=1 at edge k: load a into shreg_a, b into shreg_b, cin into carry_q; count=0.
  - Next state RUN.
  - start=0: remain in IDLE.
- RUN, each edge:
  - Cell inputs: x=shreg_a[0], y=shreg_b[0], c_in=carry_q.
  - shreg_a and shreg_b shift right by one.
  - Cell sum shifts into the MSB of the accumulating register acc.
  - carry_q <= cell c_out; count increments.
- Completion edge (count reaches WIDTH-1, i.e. edge k+WIDTH):
  - sum <= final acc (including this cycle's bit); cout <= cell c_out.
  - Next state DONE.
- DONE:
  - done=1 for exactly one cycle, between edge k+WIDTH and edge k+WIDTH+1.
  - Unconditional transition to IDLE.
- busy:
  - 1 from edge k+1 through edge k+WIDTH, i.e. exactly WIDTH cycles.
  - 0 in IDLE and DONE.
- Latency: done asserts WIDTH edges after the accepting edge. Minimum start-to-start spacing is WIDTH+2 cycles.
- start in RUN or DONE is ignored and not queued. If start is still high in IDLE, it is accepted then, so a held start gives back-to-back operations.
- a, b, cin changes after the accepting edge have no effect on the in-flight result.
- sum and cout change only on a completion edge or on reset. They never show partial results during RUN.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- WIDTH=1: RUN lasts one cycle; the completion edge is k+1.
- Reset mid-operation (any state): result discarded, done not pulsed, sum/cout return to 0. A start after rst deasserts is serviced normally.
- rst deasserting on the same edge as start=1: start is sampled normally on the first edge where rst=0.

Test Plan:
1. WIDTH=8, reset, then start with a=8'h00, b=8'h00, cin=0 -> busy high 8 cycles; done pulses on edge k+8; sum=8'h00, cout=0.
2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; busy deasserts the same edge done rises; done is 1 cycle wide.
3. a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Then a=8'h3C, b=8'h0F, cin=0 -> sum=8'h4B, cout=0; sum holds 8'h00 throughout the second RUN until its completion edge.
4. During RUN of a=8'h12, b=8'h34, cin=0: pulse start and change a/b/cin to 8'hFF/8'hFF/1 -> no restart; result sum=8'h46, cout=0. Then hold start=1 continuously -> new operations accepted every 10 cycles.
5. Assert rst at cycle 4 of RUN for a=8'hF0, b=8'h0F -> all outputs 0 immediately (asynchronous); no done pulse. Then a fresh start with a=8'h80, b=8'h80, cin=0 -> sum=8'h00, cout=1.
6. Random regression, WIDTH=8 and WIDTH=1, ≥1000 operations against a + b + cin -> exact match; done count equals accepted-start count.
